// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and data/address types for the multi-port register file.
// Optional same-cycle write-to-read bypass is selected by the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NREAD_DEF  = 2;
    localparam int NWRITE_DEF = 1;
    localparam int CNT_W_DEF  = 2;

    function automatic int addr_w(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int AW_DEF = addr_w(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: claims from issue increment, writebacks retire, clamped at 0.
// REGFILE_BYPASS_EN makes busy reflect this cycle's retirements; claims stall at saturation.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NWRITE = NWRITE_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 claim_valid,
    input  logic [AW-1:0]        claim_addr,
    output logic                 claim_ready,
    input  logic [NWRITE-1:0]    wr_en,
    input  logic [NWRITE*AW-1:0] wr_addr,
    output logic [NREGS-1:0]     busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    int               nwr   [NREGS];
    int               net   [NREGS];
    logic             fire;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            nwr[r] = 0;
        end
        for (int w = 0; w < NWRITE; w++) begin
            if (wr_en[w]) begin
                nwr[wr_addr[w*AW +: AW]] = nwr[wr_addr[w*AW +: AW]] + 1;
            end
        end
    end

    // Depends only on registered counts, so writebacks never feed claim_ready.
    always_comb begin
        claim_ready = (claim_addr == '0) || (cnt_q[claim_addr] != CNT_MAX);
        fire        = claim_valid && claim_ready;
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            net[r]   = int'(cnt_q[r]) + ((fire && (claim_addr == AW'(r))) ? 1 : 0) - nwr[r];
            cnt_d[r] = ((r == 0) || (net[r] < 0)) ? '0 : CNT_W'(net[r]);
`ifdef REGFILE_BYPASS_EN
            busy[r]  = int'(cnt_q[r]) > nwr[r];
`else
            busy[r]  = cnt_q[r] != '0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N combinational read ports, M write ports, x0 hardwired to zero.
// Zero-latency reads; claims stall when the register's counter is full. REGFILE_BYPASS_EN adds write->read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = NREAD_DEF,
    parameter int NWRITE = NWRITE_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    rs_addr,
    output logic [NREAD*XLEN-1:0]  rs_data,
    output logic [NREAD-1:0]       rs_busy,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                   claim_valid,
    input  logic [AW-1:0]          claim_addr,
    output logic                   claim_ready
);

    logic [XLEN-1:0] regs_q  [NREGS];
    logic [XLEN-1:0] regs_d  [NREGS];
    logic [AW-1:0]   rd_addr [NREAD];
    logic [NREGS-1:0] sb_busy;

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .claim_ready (claim_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .busy        (sb_busy)
    );

    // Later ports overwrite earlier ones, so the highest-index writer wins.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int w = 0; w < NWRITE; w++) begin
            if (wr_en[w]) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_addr[i]                 = rs_addr[i*AW +: AW];
            rs_data[i*XLEN +: XLEN]    = regs_q[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NWRITE; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[i]) && (rd_addr[i] != '0)) begin
                    rs_data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                end
            end
`endif
            rs_busy[i]                 = sb_busy[rd_addr[i]];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (NWRITE=2): directed scenarios then random traffic vs a reference model.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int CNT_W  = 2;
    localparam int AW     = 5;
    localparam int CMAX   = 3;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [NREAD*AW-1:0]    rs_addr = '0;
    logic [NREAD*XLEN-1:0]  rs_data;
    logic [NREAD-1:0]       rs_busy;
    logic [NWRITE-1:0]      wr_en = '0;
    logic [NWRITE*AW-1:0]   wr_addr = '0;
    logic [NWRITE*XLEN-1:0] wr_data = '0;
    logic                   claim_valid = 1'b0;
    logic [AW-1:0]          claim_addr = '0;
    logic                   claim_ready;

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE),
        .CNT_W  (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .rs_busy     (rs_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .claim_ready (claim_ready)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NREAD*XLEN-1:0] d;
        logic [NREAD-1:0]      b;
        logic                  rdy;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mregs [NREGS];
    int          mcnt  [NREGS];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic int nwr_of(input int a, input bit [1:0] we, input int wa0, input int wa1);
        return int'(we[0] && (wa0 == a)) + int'(we[1] && (wa1 == a));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit cv, input int ca, input bit [1:0] we,
                         input int wa0, input logic [31:0] wd0, input int wa1, input logic [31:0] wd1,
                         input int ra0, input int ra1, input bit chk);
        exp_t e;
        int   ra, net;
        bit   fire;
        @(posedge clock);
        #1;
        reset       = rst;
        claim_valid = cv;
        claim_addr  = AW'(ca);
        wr_en       = we;
        wr_addr     = {AW'(wa1), AW'(wa0)};
        wr_data     = {wd1, wd0};
        rs_addr     = {AW'(ra1), AW'(ra0)};
        if (chk) begin
            for (int i = 0; i < NREAD; i++) begin
                ra = (i == 0) ? ra0 : ra1;
                e.d[i*XLEN +: XLEN] = mregs[ra];
`ifdef REGFILE_BYPASS_EN
                if (ra != 0) begin
                    if (we[0] && wa0 == ra) e.d[i*XLEN +: XLEN] = wd0;
                    if (we[1] && wa1 == ra) e.d[i*XLEN +: XLEN] = wd1;
                end
                e.b[i] = (mcnt[ra] - nwr_of(ra, we, wa0, wa1)) > 0;
`else
                e.b[i] = mcnt[ra] > 0;
`endif
            end
            e.rdy = (ca == 0) || (mcnt[ca] < CMAX);
            sbq.push_back(e);
        end
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mregs[r] = '0;
                mcnt[r]  = 0;
            end
        end else begin
            fire = cv && ((ca == 0) || (mcnt[ca] < CMAX));
            for (int a = 1; a < NREGS; a++) begin
                net     = mcnt[a] + int'(fire && ca == a) - nwr_of(a, we, wa0, wa1);
                mcnt[a] = (net < 0) ? 0 : net;
            end
            if (we[0] && wa0 != 0) mregs[wa0] = wd0;
            if (we[1] && wa1 != 0) mregs[wa1] = wd1;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("rs_data0", rs_data[0 +: XLEN], e.d[0 +: XLEN]);
                check("rs_data1", rs_data[XLEN +: XLEN], e.d[XLEN +: XLEN]);
                check("rs_busy0", 32'(rs_busy[0]), 32'(e.b[0]));
                check("rs_busy1", 32'(rs_busy[1]), 32'(e.b[1]));
                check("claim_ready", 32'(claim_ready), 32'(e.rdy));
            end
        end
    end

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            mregs[r] = '0;
            mcnt[r]  = 0;
        end
        drive(0, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        // reset clears data after a write
        drive(1, 0, 0, 2'b01, 5, 32'hDEADBEEF, 0, 32'h0, 5, 0, 1);
        drive(0, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0, 5, 0, 1);
        drive(1, 0, 5, 2'b00, 0, 32'h0, 0, 32'h0, 5, 5, 1);
        // x0 ignores writes and claims
        drive(1, 1, 0, 2'b01, 0, 32'h12345678, 0, 32'h0, 0, 0, 1);
        drive(1, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        // saturation on x3, then drain
        for (int k = 0; k < 4; k++) drive(1, 1, 3, 2'b00, 0, 32'h0, 0, 32'h0, 3, 3, 1);
        drive(1, 0, 3, 2'b01, 3, 32'h11, 0, 32'h0, 3, 3, 1);
        drive(1, 0, 3, 2'b01, 3, 32'h22, 0, 32'h0, 3, 3, 1);
        drive(1, 0, 3, 2'b01, 3, 32'h33, 0, 32'h0, 3, 3, 1);
        drive(1, 0, 3, 2'b00, 0, 32'h0, 0, 32'h0, 3, 3, 1);
        // claim and retire x7 together
        drive(1, 1, 7, 2'b00, 0, 32'h0, 0, 32'h0, 7, 7, 1);
        drive(1, 1, 7, 2'b01, 7, 32'hA5, 0, 32'h0, 7, 7, 1);
        drive(1, 0, 7, 2'b00, 0, 32'h0, 0, 32'h0, 7, 7, 1);
        // two ports write x9
        drive(1, 1, 9, 2'b00, 0, 32'h0, 0, 32'h0, 9, 9, 1);
        drive(1, 1, 9, 2'b00, 0, 32'h0, 0, 32'h0, 9, 9, 1);
        drive(1, 0, 9, 2'b11, 9, 32'h1, 9, 32'h2, 9, 9, 1);
        drive(1, 0, 9, 2'b00, 0, 32'h0, 0, 32'h0, 9, 9, 1);
        // read x4 in the cycle it is written back
        drive(1, 1, 4, 2'b00, 0, 32'h0, 0, 32'h0, 4, 0, 1);
        drive(1, 0, 4, 2'b01, 4, 32'hCAFE, 0, 32'h0, 4, 4, 1);
        drive(1, 0, 4, 2'b00, 0, 32'h0, 0, 32'h0, 4, 4, 1);
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom_range(0, 7), 1);
        end
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clock);
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
